// File: rtl/seven_seg_pkg.sv
// Shared definitions for the multiplexed hex display path: segment codes,
// digit-select codes and the receive-side decoder states.
package seven_seg_pkg;

   localparam logic [1:0] ANODE_LO = 2'b10;
   localparam logic [1:0] ANODE_HI = 2'b01;

   // Positive-logic patterns, bit 6..0 per the team segment map.
   localparam logic [6:0] SEG_0 = 7'h77;
   localparam logic [6:0] SEG_1 = 7'h60;
   localparam logic [6:0] SEG_2 = 7'h3B;
   localparam logic [6:0] SEG_3 = 7'h79;
   localparam logic [6:0] SEG_4 = 7'h6C;
   localparam logic [6:0] SEG_5 = 7'h5D;
   localparam logic [6:0] SEG_6 = 7'h5F;
   localparam logic [6:0] SEG_7 = 7'h70;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h7C;
   localparam logic [6:0] SEG_A = 7'h7E;
   localparam logic [6:0] SEG_B = 7'h4F;
   localparam logic [6:0] SEG_C = 7'h17;
   localparam logic [6:0] SEG_D = 7'h6B;
   localparam logic [6:0] SEG_E = 7'h1F;
   localparam logic [6:0] SEG_F = 7'h1E;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      WAIT_HI = 2'd1,
      WAIT_LO = 2'd2
   } dec_state_t;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
      case (n)
         4'h0: return SEG_0;
         4'h1: return SEG_1;
         4'h2: return SEG_2;
         4'h3: return SEG_3;
         4'h4: return SEG_4;
         4'h5: return SEG_5;
         4'h6: return SEG_6;
         4'h7: return SEG_7;
         4'h8: return SEG_8;
         4'h9: return SEG_9;
         4'hA: return SEG_A;
         4'hB: return SEG_B;
         4'hC: return SEG_C;
         4'hD: return SEG_D;
         4'hE: return SEG_E;
         default: return SEG_F;
      endcase
   endfunction

endpackage

// File: rtl/seven_seg_decoder_seg_to_hex.sv
// Reverse lookup of a positive-logic 7-segment pattern; hit is low for any
// pattern that is not one of the 16 hex glyphs.
module seg_to_hex
   import seven_seg_pkg::*;
(
   input  logic [6:0] pattern,
   output logic       hit,
   output logic [3:0] nibble
);

   always_comb begin
      hit    = 1'b0;
      nibble = 4'h0;
      for (int i = 0; i < 16; i++) begin
         if (pattern == hex_to_seg(4'(i))) begin
            hit    = 1'b1;
            nibble = 4'(i);
         end
      end
   end

endmodule

// File: rtl/seven_seg_decoder.sv
// Recovers the byte shown on a two-digit multiplexed hex display and publishes
// it once the same complete frame has been seen MATCH_FRAMES times in a row.
module seven_seg_decoder
   import seven_seg_pkg::*;
#(
   parameter int MATCH_FRAMES = 4,
   parameter int TIMEOUT      = 1024,
   parameter bit ACTIVE_LOW   = 1'b1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] SEG_IN,
   input  logic [1:0] ANODE_IN,
   output logic [7:0] BYTE_OUT,
   output logic       BYTE_VALID,
   output logic       LOCKED,
   output logic       DIGIT_ERR
);

   localparam logic [3:0]  MATCH_MAX = 4'(MATCH_FRAMES);
   localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);

   logic [6:0]  seg_q;
   logic [1:0]  anode_q;
   logic        sample_vld;

   logic        hit;
   logic [3:0]  nibble;

   dec_state_t  state, state_nxt;
   logic [3:0]  lo_q, lo_nxt;
   logic [7:0]  prev_q, prev_nxt;
   logic [3:0]  match_cnt, match_nxt;
   logic [15:0] timeout_cnt, timeout_nxt;
   logic [7:0]  byte_nxt;
   logic        valid_nxt, locked_nxt, err_nxt;

   logic        lo_ok, hi_ok, err, frame_done, timeout_hit;
   logic [7:0]  cand;
   logic [3:0]  cnt_inc;

   // Stage 1: polarity-normalise and drop the decimal point.
   always_ff @(posedge CLK) begin
      if (RST) begin
         seg_q      <= '0;
         anode_q    <= '0;
         sample_vld <= 1'b0;
      end else begin
         seg_q      <= 7'((ACTIVE_LOW ? ~SEG_IN : SEG_IN) & 8'h7F);
         anode_q    <= ANODE_IN;
         sample_vld <= 1'b1;
      end
   end

   seg_to_hex u_seg_to_hex (
      .pattern (seg_q),
      .hit     (hit),
      .nibble  (nibble)
   );

   assign lo_ok       = sample_vld && hit && (anode_q == ANODE_LO);
   assign hi_ok       = sample_vld && hit && (anode_q == ANODE_HI);
   assign err         = sample_vld && !(lo_ok || hi_ok);
   assign frame_done  = hi_ok && (state == WAIT_HI);
   assign timeout_hit = !frame_done && (timeout_cnt == TO_LAST);
   assign cand        = {nibble, lo_q};
   // match_cnt == 0 means there is no previous frame to compare against.
   assign cnt_inc     = (match_cnt != 4'd0 && cand == prev_q)
                        ? ((match_cnt == MATCH_MAX) ? match_cnt : match_cnt + 4'd1)
                        : 4'd1;

   always_comb begin
      state_nxt   = state;
      lo_nxt      = lo_q;
      prev_nxt    = prev_q;
      match_nxt   = match_cnt;
      timeout_nxt = timeout_cnt + 16'd1;
      byte_nxt    = BYTE_OUT;
      valid_nxt   = 1'b0;
      locked_nxt  = LOCKED;
      err_nxt     = 1'b0;

      case (state)
         HUNT: begin
            if (lo_ok) begin
               lo_nxt    = nibble;
               state_nxt = WAIT_HI;
            end
         end
         WAIT_HI: begin
            if (lo_ok) begin
               lo_nxt = nibble;
            end else if (hi_ok) begin
               state_nxt = WAIT_LO;
            end
         end
         WAIT_LO: begin
            if (lo_ok) begin
               lo_nxt    = nibble;
               state_nxt = WAIT_HI;
            end
         end
         default: state_nxt = HUNT;
      endcase

      if (frame_done) begin
         prev_nxt    = cand;
         match_nxt   = cnt_inc;
         timeout_nxt = '0;
         if (cnt_inc == MATCH_MAX && (!LOCKED || cand != BYTE_OUT)) begin
            byte_nxt   = cand;
            valid_nxt  = 1'b1;
            locked_nxt = 1'b1;
         end
      end

      if (timeout_hit) begin
         locked_nxt  = 1'b0;
         state_nxt   = HUNT;
         match_nxt   = '0;
         timeout_nxt = '0;
      end

      // Errors restart frame tracking but leave the published byte and lock alone.
      if (err) begin
         err_nxt   = 1'b1;
         state_nxt = HUNT;
         match_nxt = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= HUNT;
         lo_q        <= '0;
         prev_q      <= '0;
         match_cnt   <= '0;
         timeout_cnt <= '0;
         BYTE_OUT    <= '0;
         BYTE_VALID  <= 1'b0;
         LOCKED      <= 1'b0;
         DIGIT_ERR   <= 1'b0;
      end else begin
         state       <= state_nxt;
         lo_q        <= lo_nxt;
         prev_q      <= prev_nxt;
         match_cnt   <= match_nxt;
         timeout_cnt <= timeout_nxt;
         BYTE_OUT    <= byte_nxt;
         BYTE_VALID  <= valid_nxt;
         LOCKED      <= locked_nxt;
         DIGIT_ERR   <= err_nxt;
      end
   end

endmodule

// File: doc/seven_seg_decoder.md
Name: seven_seg_decoder

Overview:
- Receive-side counterpart of the two-digit multiplexed hex display driver.
- Samples the scanned segment bus (SEG_IN) and digit-select lines (ANODE_IN), decodes each digit pattern back to a nibble, and assembles the frames into bytes.
- Publishes a byte only after it has been stable for a qualifying number of frames.
- Used for loopback self-test of the display path, and for reading display-style outputs from the CAN node.

Parameters:
- MATCH_FRAMES, 4: consecutive identical complete frames required before publishing (legal 1..15).
- TIMEOUT, 1024: cycles without a completed frame before lock is dropped (legal 4..65535).
- ACTIVE_LOW, 1: 1 = SEG_IN is inverted (lit segment = 0); 0 = positive logic.

Ports:
- CLK  in  1  single system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- SEG_IN  in  8  segment bus; bit 7 = decimal point (ignored); bits 6..0 per the team segment map.
- ANODE_IN  in  2  digit select; 2'b10 = low digit (nibble [3:0]); 2'b01 = high digit (nibble [7:4]); 00/11 are illegal.
- BYTE_OUT  out  8  last published byte.
- BYTE_VALID  out  1  one-cycle pulse when BYTE_OUT is updated.
- LOCKED  out  1  high while the decoder is tracking a stable display.
- DIGIT_ERR  out  1  one-cycle pulse on an unrecognised pattern or an illegal ANODE_IN.

Behaviour:
- Reset values: BYTE_OUT=0, BYTE_VALID=0, LOCKED=0, DIGIT_ERR=0, FSM=HUNT, match_cnt=0, timeout_cnt=0.
- The input-stage sample-valid flag is cleared on reset, so no DIGIT_ERR is produced from reset contents.
- Stage 1: SEG_IN and ANODE_IN are registered every cycle.
  - If ACTIVE_LOW=1, SEG_IN is inverted.
  - Bit 7 is masked to 0.
- Stage 2: the pattern is decoded via the 16-entry table; anything else is a miss:
  - 0:77 1:60 2:3B 3:79 4:6C 5:5D 6:5F 7:70
  - 8:7F 9:7C A:7E B:4F C:17 D:6B E:1F F:1E (hex, positive logic).
- Error handling (miss or illegal anode):
  - DIGIT_ERR pulses; FSM goes to HUNT; match_cnt clears.
  - LOCKED and BYTE_OUT are unchanged.
- FSM:
  - HUNT: valid low digit -> store lo nibble, go to WAIT_HI. High digits are ignored.
  - WAIT_HI: valid low digit -> overwrite lo, stay. Valid high digit -> frame complete {hi,lo}, go to WAIT_LO.
  - WAIT_LO: valid high digit -> overwrite hi, stay (slow scan tolerated). Valid low digit -> store lo, go to WAIT_HI.
- Frame completion, candidate C={hi,lo}:
  - If C equals the previous frame, match_cnt increments, saturating at MATCH_FRAMES. Otherwise match_cnt=1.
  - timeout_cnt clears.
- Publish: when match_cnt reaches MATCH_FRAMES, and (LOCKED=0 or C≠BYTE_OUT):
  - BYTE_OUT<=C, BYTE_VALID pulses, LOCKED<=1.
  - A held identical byte does not re-pulse.
- Latency: when the completing high-digit sample is on the pins during cycle k, BYTE_OUT/BYTE_VALID are visible in cycle k+2.
- Timeout: timeout_cnt increments every cycle without a frame completion. On reaching TIMEOUT:
  - LOCKED<=0, FSM=HUNT, match_cnt=0, timeout_cnt=0.
  - BYTE_OUT holds.
- Simultaneous events:
  - An error in the same cycle as a timeout: both actions apply; DIGIT_ERR pulses.
  - RST overrides everything; a reset mid-frame discards the partial frame.

Decomposition:
- Package seven_seg_pkg holds:
  - the 16 segment-code constants (shared with the display driver);
  - the anode codes ANODE_LO=2'b10 and ANODE_HI=2'b01;
  - the FSM state encoding HUNT/WAIT_HI/WAIT_LO.
- Sub-module seg_to_hex: combinational 7-bit pattern -> {hit, nibble[3:0]}, instantiated once in stage 2.

Test Plan:
- Driver-style scan with byte 0x3A, alternating each cycle, MATCH_FRAMES=4 -> single BYTE_VALID with BYTE_OUT=0x3A two cycles after the 4th high sample; LOCKED=1; no further pulses while held.
- Switch the displayed byte 0x3A -> 0xC5 mid-scan -> one pulse with BYTE_OUT=0xC5 after 4 matching 0xC5 frames; no pulse for mixed transitional frames.
- Inject SEG pattern 0x00 (blank) on one low-digit slot -> DIGIT_ERR pulse; match_cnt restarts; publish delayed by the full 4 frames.
- Drive ANODE_IN=2'b11 for one cycle while locked -> DIGIT_ERR pulse, FSM=HUNT; LOCKED stays 1 and BYTE_OUT is unchanged.
- Freeze ANODE_IN at 2'b10 for 1024 cycles -> LOCKED falls at cycle 1024; BYTE_OUT holds. Resume scanning of the same byte -> BYTE_VALID re-pulses with the same value.
- Slow scan (each digit held 50 cycles) with 0x81 -> published as 0x81. Assert RST mid-frame -> all outputs 0; the next publish still requires 4 full frames.
